// File: rtl/fetch_unit_if_if.sv
// Instruction-memory request bus between the IF-stage fetch unit (master)
// and the instruction memory (slave); im_ready may be held low for wait states.
interface fetch_unit_if_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_rdata
  );
endinterface

// File: rtl/fetch_unit_if.sv
// IF-stage fetch unit: one-entry output buffer, one branch delay slot.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_err and a HALT state.
module fetch_unit_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ir_en,
  input  logic [1:0]            pc_select,
  input  logic                  if_branch,
  input  logic [31:0]           bpc,
  input  logic [31:0]           jpc,
  input  logic [31:0]           raddr,
  fetch_unit_if_if.master       im,
  output logic [31:0]           Instr_IF,
  output logic [31:0]           pc_IF,
  output logic                  fetch_stall
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  fetch_err
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    ST_HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  logic        consume;
  logic        redirect_now;
  logic [31:0] target;
  logic [31:0] req_addr;
  logic        req;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d        = err_q;
`endif
    target       = fetch_pc_q;
    redirect_now = 1'b0;

    consume = ir_en & valid_q;

    case (pc_select)
      2'd1: begin
        target       = bpc;
        redirect_now = consume & if_branch;
      end
      2'd2: begin
        target       = jpc;
        redirect_now = consume;
      end
      2'd3: begin
        target       = raddr;
        redirect_now = consume;
      end
      default: ;
    endcase

    req_addr = redirect_now ? target : fetch_pc_q;
    req      = (state_q == ST_RUN) & (~valid_q | consume);

    if (state_q == ST_BOOT) state_d = ST_RUN;

`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned request never reaches memory; the unit parks in HALT.
    if (req && (req_addr[1:0] != 2'b00)) begin
      req     = 1'b0;
      err_d   = 1'b1;
      state_d = ST_HALT;
      valid_d = 1'b0;
    end
`endif

    if (req && im.im_ready) begin
      instr_d    = im.im_rdata;
      pc_d       = req_addr;
      valid_d    = 1'b1;
      fetch_pc_d = req_addr + 32'(PC_STEP);
    end else if (consume) begin
      valid_d = 1'b0;
      // Redirect lost to a wait state: retry the target on later cycles.
      if (redirect_now) fetch_pc_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign im.im_req   = req;
  assign im.im_addr  = req_addr;
  assign Instr_IF    = valid_q ? instr_q : '0;
  assign pc_IF       = pc_q;
  assign fetch_stall = ~valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_err   = err_q;
`endif

endmodule

// File: tb/tb_fetch_unit_if.sv
// Randomized bench for fetch_unit_if: a program-order model predicts each
// consumed (pc, instr) pair; a negedge monitor pops and compares.
module tb_fetch_unit_if;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_en;
  logic [1:0]  pc_select;
  logic        if_branch;
  logic [31:0] bpc, jpc, raddr;
  logic [31:0] instr_if, pc_if;
  logic        fetch_stall;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  fetch_unit_if_if bus ();

  fetch_unit_if #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_en      (ir_en),
    .pc_select  (pc_select),
    .if_branch  (if_branch),
    .bpc        (bpc),
    .jpc        (jpc),
    .raddr      (raddr),
    .im         (bus),
    .Instr_IF   (instr_if),
    .pc_IF      (pc_if),
    .fetch_stall(fetch_stall)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address, so every word identifies its pc.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.im_rdata = word_of(bus.im_addr);

  int          checks   = 0;
  int          failures = 0;
  int          consumed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] exp_pc;
  bit          zw;
  int          zw_cnt;
  bit          prev_ok;
  logic        prev_req, prev_ready;
  logic [31:0] prev_addr;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every consume must deliver the next program-order pc.
  always @(negedge clk) begin
    if (reset) begin
      prev_ok = 1'b0;
    end else begin
      if (ir_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual=consume expected=none at %0t", $time);
        end else begin
          exp_pc = exp_q.pop_front();
          check32("pc_IF", pc_if, exp_pc);
          check32("Instr_IF", instr_if, word_of(exp_pc));
          consumed++;
        end
      end
      if (fetch_stall) check32("nop_when_invalid", instr_if, 32'h0);
      if (zw && zw_cnt >= 3) check32("zero_wait_throughput", {31'b0, fetch_stall}, 32'h0);
      if (prev_ok && prev_req && !prev_ready) begin
        check32("wait_req_held", {31'b0, bus.im_req}, 32'h1);
        check32("wait_addr_held", bus.im_addr, prev_addr);
      end
      prev_ok    = 1'b1;
      prev_req   = bus.im_req;
      prev_ready = bus.im_ready;
      prev_addr  = bus.im_addr;
    end
  end

  task automatic drive_cycle(input bit want, input int ready_pct, input bit seq_only);
    int r;
    bit redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    if (zw) zw_cnt++;
    bus.im_ready = ($urandom_range(0, 99) < ready_pct);
    ir_en        = want & ~fetch_stall;
    r            = $urandom_range(0, 7);
    pc_select    = seq_only ? 2'd0 : ((r < 4) ? 2'd0 : 2'(r - 4));
    if_branch    = $urandom_range(0, 1) == 1;
    bpc          = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
    jpc          = 32'h4000 + (32'($urandom_range(0, 255)) << 2);
    raddr        = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    if (ir_en) begin
      redir = 1'b0;
      tgt   = 32'h0;
      case (pc_select)
        2'd1: begin redir = if_branch; tgt = bpc; end
        2'd2: begin redir = 1'b1; tgt = jpc; end
        2'd3: begin redir = 1'b1; tgt = raddr; end
        default: ;
      endcase
      model_pc = redir ? tgt : model_pc + 32'd4;
      exp_q.push_back(model_pc);
    end
  endtask

  task automatic do_reset(input bit ready_in_reset);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    ir_en        = 1'b0;
    pc_select    = 2'd0;
    bus.im_ready = ready_in_reset;
    zw           = 1'b0;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.im_ready = 1'b0;
    check32("reset_stall", {31'b0, fetch_stall}, 32'h1);
    check32("reset_instr", instr_if, 32'h0);
    check32("reset_pc_IF", pc_if, RESET_PC);
    check32("boot_no_req", {31'b0, bus.im_req}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check32("reset_fetch_err", {31'b0, fetch_err}, 32'h0);
`endif
    exp_q.delete();
    model_pc = RESET_PC;
    exp_q.push_back(RESET_PC);
  endtask

  task automatic boot_step();
    @(posedge clk);
    #1;
    ir_en = 1'b0;
    check32("first_req", {31'b0, bus.im_req}, 32'h1);
    check32("first_addr", bus.im_addr, RESET_PC);
    bus.im_ready = 1'b1;
  endtask

  initial begin
    int n;
    reset        = 1'b0;
    ir_en        = 1'b0;
    pc_select    = 2'd0;
    if_branch    = 1'b0;
    bpc          = '0;
    jpc          = '0;
    raddr        = '0;
    bus.im_ready = 1'b0;
    zw           = 1'b0;
    zw_cnt       = 0;
    prev_ok      = 1'b0;

    do_reset(1'b0);
    boot_step();
    zw = 1'b1; zw_cnt = 1;
    repeat (12) drive_cycle(1'b1, 100, 1'b1);
    zw = 1'b0;
    repeat (3) drive_cycle(1'b1, 0, 1'b1);
    repeat (4) drive_cycle(1'b1, 100, 1'b1);
    zw = 1'b1; zw_cnt = 0;
    repeat (40) drive_cycle(1'b1, 100, 1'b0);
    zw = 1'b0;
    repeat (1500) drive_cycle($urandom_range(0, 99) < 70, 55, 1'b0);
    zw = 1'b1; zw_cnt = 0;
    repeat (30) drive_cycle(1'b1, 100, 1'b0);
    zw = 1'b0;

    // Reset in the middle of a wait state, with im_ready high during reset.
    n = 0;
    do begin
      drive_cycle(1'b1, 0, 1'b1);
      n++;
    end while (!(fetch_stall && bus.im_req) && n < 20);
    check32("wait_reached", {31'b0, fetch_stall & bus.im_req}, 32'h1);
    repeat (2) drive_cycle(1'b0, 0, 1'b1);
    do_reset(1'b1);
    boot_step();
    repeat (400) drive_cycle($urandom_range(0, 99) < 70, 60, 1'b0);

`ifdef FETCH_ALIGN_CHECK_EN
    do_reset(1'b0);
    boot_step();
    repeat (4) drive_cycle(1'b1, 100, 1'b1);
    @(posedge clk);
    #1;
    bus.im_ready = 1'b1;
    ir_en        = ~fetch_stall;
    pc_select    = 2'd2;
    jpc          = 32'h0000_3102;
    #1;
    check32("misaligned_no_req", {31'b0, bus.im_req}, 32'h0);
    @(posedge clk);
    #1;
    ir_en     = 1'b0;
    pc_select = 2'd0;
    check32("fetch_err_set", {31'b0, fetch_err}, 32'h1);
    repeat (5) begin
      @(posedge clk);
      #1;
      check32("halt_no_req", {31'b0, bus.im_req}, 32'h0);
      check32("halt_stall", {31'b0, fetch_stall}, 32'h1);
      check32("halt_err_sticky", {31'b0, fetch_err}, 32'h1);
    end
`endif

    checks++;
    if (consumed < 200) begin
      failures++;
      $display("FAIL progress actual=%0d consumes expected>=200", consumed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
